// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes RISC-V immediates from a 32-bit instruction
// and delivers them through a two-entry (output + skid) valid/ready buffer.
module imm_decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter bit          RV64_EN    = 1'b0,
  parameter bit          CSR_IMM_EN = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic [31:0]     instr_in,
  input  logic            in_valid_in,
  output logic            in_ready_out,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out,
  output logic            illegal_out,
  output logic            out_valid_out,
  input  logic            out_ready_in
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  entry_t      dec_c;
  logic        valid_q, ready_q;
  logic        in_xfer_c, out_xfer_c;
  logic [4:0]  op_c;
  logic [31:0] imm32_c;
  logic [2:0]  fmt_c;
  logic        sext_c;

  assign op_c = instr_in[6:2];

  // Decode the incoming word into a 32-bit immediate, then extend to XLEN.
  always_comb begin
    imm32_c = '0;
    fmt_c   = FMT_NONE;
    sext_c  = 1'b1;
    dec_c   = '0;
    case (op_c)
      5'b01101, 5'b00101: begin
        fmt_c   = FMT_U;
        imm32_c = {instr_in[31:12], 12'b0};
      end
      5'b11011: begin
        fmt_c   = FMT_J;
        imm32_c = 32'($signed({instr_in[31], instr_in[19:12], instr_in[20],
                               instr_in[30:21], 1'b0}));
      end
      5'b11001, 5'b00000, 5'b00100: begin
        fmt_c   = FMT_I;
        imm32_c = 32'($signed(instr_in[31:20]));
      end
      5'b00110: begin
        if (RV64_EN) begin
          fmt_c   = FMT_I;
          imm32_c = 32'($signed(instr_in[31:20]));
        end
      end
      5'b11000: begin
        fmt_c   = FMT_B;
        imm32_c = 32'($signed({instr_in[31], instr_in[7], instr_in[30:25],
                               instr_in[11:8], 1'b0}));
      end
      5'b01000: begin
        fmt_c   = FMT_S;
        imm32_c = 32'($signed({instr_in[31:25], instr_in[11:7]}));
      end
      5'b11100: begin
        if (CSR_IMM_EN) begin
          fmt_c   = FMT_Z;
          imm32_c = 32'(instr_in[19:15]);
          sext_c  = 1'b0;
        end
      end
      default: ;
    endcase
    dec_c.imm     = sext_c ? XLEN'($signed(imm32_c)) : XLEN'(imm32_c);
    dec_c.fmt     = fmt_c;
    dec_c.illegal = 1'b0;
    // Compressed / non-32-bit encodings carry no immediate.
    if (instr_in[1:0] != 2'b11) begin
      dec_c         = '0;
      dec_c.illegal = 1'b1;
    end
  end

  assign in_xfer_c  = in_valid_in && ready_q;
  assign out_xfer_c = valid_q && out_ready_in;

  // Buffer next-state: occupancy transitions and payload movement.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_c) begin
          out_d   = dec_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer_c && out_xfer_c) begin
          out_d = dec_c;
        end else if (in_xfer_c) begin
          skid_d  = dec_c;
          state_d = ST_FULL;
        end else if (out_xfer_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer_c) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_in) begin
      state_d = ST_EMPTY;
    end
  end

  // State, payload and handshake registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_FULL);
    end
  end

  assign in_ready_out  = ready_q;
  assign out_valid_out = valid_q;
  assign imm_out       = out_q.imm;
  assign fmt_out       = out_q.fmt;
  assign illegal_out   = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: two configurations share one stimulus stream;
// accepted instructions are queued and a negedge monitor checks every output.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] instr;
  logic        in_valid;
  logic        out_ready;

  logic        a_ir, a_ov, a_ill;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic        b_ir, b_ov, b_ill;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .RV64_EN(1'b0), .CSR_IMM_EN(1'b1)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .instr_in(instr),
    .in_valid_in(in_valid), .in_ready_out(a_ir), .imm_out(a_imm),
    .fmt_out(a_fmt), .illegal_out(a_ill), .out_valid_out(a_ov),
    .out_ready_in(out_ready));

  imm_decode_stage #(.XLEN(64), .RV64_EN(1'b1), .CSR_IMM_EN(1'b0)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .instr_in(instr),
    .in_valid_in(in_valid), .in_ready_out(b_ir), .imm_out(b_imm),
    .fmt_out(b_fmt), .illegal_out(b_ill), .out_valid_out(b_ov),
    .out_ready_in(out_ready));

  // Reference decode: gather the immediate field, then sign-extend arithmetically.
  function automatic exp_t ref_dec(input logic [31:0] ins, input bit rv64, input bit csr_en);
    exp_t   r;
    longint raw;
    int     w;
    r   = '0;
    raw = 0;
    w   = 0;
    case (ins[6:2])
      5'b01101, 5'b00101: begin r.fmt = 3'd4; raw = longint'({ins[31:12], 12'b0}); w = 32; end
      5'b11011: begin r.fmt = 3'd5; raw = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); w = 21; end
      5'b11001, 5'b00000, 5'b00100: begin r.fmt = 3'd1; raw = longint'(ins[31:20]); w = 12; end
      5'b00110: if (rv64) begin r.fmt = 3'd1; raw = longint'(ins[31:20]); w = 12; end
      5'b11000: begin r.fmt = 3'd3; raw = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); w = 13; end
      5'b01000: begin r.fmt = 3'd2; raw = longint'({ins[31:25], ins[11:7]}); w = 12; end
      5'b11100: if (csr_en) begin r.fmt = 3'd6; raw = longint'(ins[19:15]); w = 0; end
      default: ;
    endcase
    if (w > 0 && raw >= (longint'(1) <<< (w - 1))) raw = raw - (longint'(1) <<< w);
    r.imm = 64'(raw);
    if (ins[1:0] != 2'b11) begin
      r.imm = '0;
      r.fmt = 3'd0;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] i, input logic r, input logic f);
    in_valid  = v;
    instr     = i;
    out_ready = r;
    flush     = f;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  ops[11];
    logic [31:0] r;
    logic [4:0]  op;
    logic [1:0]  lo;
    ops = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00100,
            5'b00110, 5'b11000, 5'b01000, 5'b11100, 5'b10101};
    r  = $urandom();
    op = ops[$urandom_range(0, 10)];
    lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
    return {r[31:7], op, lo};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_valid"}, 64'(a_ov), 64'd0);
    chk({tag, "_a_ready"}, 64'(a_ir), 64'd1);
    chk({tag, "_a_imm"},   64'(a_imm), 64'd0);
    chk({tag, "_a_fmt"},   64'(a_fmt), 64'd0);
    chk({tag, "_a_ill"},   64'(a_ill), 64'd0);
    chk({tag, "_b_valid"}, 64'(b_ov), 64'd0);
    chk({tag, "_b_ready"}, 64'(b_ir), 64'd1);
    chk({tag, "_b_imm"},   b_imm, 64'd0);
    chk({tag, "_b_fmt"},   64'(b_fmt), 64'd0);
    chk({tag, "_b_ill"},   64'(b_ill), 64'd0);
  endtask

  // Acceptance tracker: records accepted instructions, retires delivered ones.
  always @(posedge clk or negedge rst_n) begin : tracker
    bit ox, ix;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      ox = (q.size() > 0) && out_ready;
      ix = in_valid && (q.size() < 2);
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(instr);
    end
  end

  // Monitor: outputs must reflect the head of the accepted-instruction queue.
  always @(negedge clk) begin : monitor
    exp_t ra, rb;
    if (rst_n) begin
      chk("a_out_valid", 64'(a_ov), 64'(q.size() > 0));
      chk("a_in_ready",  64'(a_ir), 64'(q.size() < 2));
      chk("b_out_valid", 64'(b_ov), 64'(q.size() > 0));
      chk("b_in_ready",  64'(b_ir), 64'(q.size() < 2));
      if (q.size() > 0) begin
        ra = ref_dec(q[0], 1'b0, 1'b1);
        rb = ref_dec(q[0], 1'b1, 1'b0);
        chk("a_imm", 64'(a_imm), 64'(ra.imm[31:0]));
        chk("a_fmt", 64'(a_fmt), 64'(ra.fmt));
        chk("a_ill", 64'(a_ill), 64'(ra.ill));
        chk("b_imm", b_imm, rb.imm);
        chk("b_fmt", 64'(b_fmt), 64'(rb.fmt));
        chk("b_ill", 64'(b_ill), 64'(rb.ill));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    #2 rst_n = 1'b1;

    // Directed decodes with an always-ready consumer.
    @(negedge clk); drv(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    @(negedge clk);
    chk("addi_a_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi_a_fmt", 64'(a_fmt), 64'd1);
    chk("addi_a_valid", 64'(a_ov), 64'd1);
    drv(1'b1, 32'h800000B7, 1'b1, 1'b0);
    @(negedge clk);
    chk("lui_b_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_b_fmt", 64'(b_fmt), 64'd4);
    drv(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    @(negedge clk);
    chk("beq_b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_b_fmt", 64'(b_fmt), 64'd3);
    drv(1'b1, 32'h00000011, 1'b1, 1'b0);
    @(negedge clk);
    chk("cmp_a_ill", 64'(a_ill), 64'd1);
    chk("cmp_a_imm", 64'(a_imm), 64'd0);
    chk("cmp_a_fmt", 64'(a_fmt), 64'd0);
    drv(1'b1, 32'h0010009B, 1'b1, 1'b0);
    @(negedge clk);
    chk("opimm32_a_fmt", 64'(a_fmt), 64'd0);
    chk("opimm32_b_fmt", 64'(b_fmt), 64'd1);
    chk("opimm32_b_imm", b_imm, 64'd1);
    drv(1'b1, 32'hABC7D073, 1'b1, 1'b0);
    @(negedge clk);
    chk("csr_a_fmt", 64'(a_fmt), 64'd6);
    chk("csr_a_imm", 64'(a_imm), 64'd15);
    chk("csr_b_fmt", 64'(b_fmt), 64'd0);
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    // Backpressure: fill both entries, hold, then drain back-to-back.
    drv(1'b1, 32'h00500113, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 32'h00A12423, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_ready", 64'(a_ir), 64'd0);
    chk("full_a_imm", 64'(a_imm), 64'd5);
    drv(1'b1, 32'h7FF00093, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_a_imm", 64'(a_imm), 64'd5);
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_b_entry", 64'(a_imm), 64'd8);
    chk("drain_b_fmt", 64'(a_fmt), 64'd2);
    @(negedge clk);
    chk("drained_valid", 64'(a_ov), 64'd0);

    // Flush while full with a new instruction offered.
    drv(1'b1, 32'h00100093, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 32'h00200093, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 32'h00300093, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_full_valid", 64'(a_ov), 64'd0);
    chk("flush_full_ready", 64'(a_ir), 64'd1);
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_no_emit", 64'(a_ov), 64'd0);

    // Flush in ONE with simultaneous in and out transfers.
    drv(1'b1, 32'h00400093, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 32'h00500093, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_one_valid", 64'(b_ov), 64'd0);
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 800; i++) begin
      drv(1'($urandom_range(0, 3) != 0), rand_instr(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
      @(negedge clk);
    end

    // Asynchronous reset while full.
    drv(1'b1, 32'h00600093, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 32'h00700093, 1'b0, 1'b0);
    @(negedge clk); drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_reset_full", 64'(a_ir), 64'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    drv(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
